taxi_display: RTL

Display-side consumer of the taxi meter outputs: takes the fare (money, 0.1-yuan units), distance (run, metres) and waiting time (waitTime, minutes). Converts the selected value to BCD with an iterative shift-add-3 engine, formats decimal point and leading-zero blanking, and drives a 6-digit multiplexed 7-segment display. Sits between the meter core and the board pins.

---
 rtl/taxi_disp_pkg.sv | 70 +++++++
 rtl/taxi_display_bin2bcd_seq.sv | 91 +++++++++
 rtl/taxi_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/taxi_disp_pkg.sv
// Shared definitions for the taxi meter display path.
//   - source encodings used by the sel input and the src output
//   - digit count and binary width of the converter
//   - converter FSM state type
//   - 7-segment lookup and per-source formatting tables
package taxi_disp_pkg;

  localparam int NDIG = 6;
  localparam int BINW = 18;
  localparam int BCDW = 4 * NDIG;

  localparam logic [1:0] SRC_MONEY = 2'd0;
  localparam logic [1:0] SRC_RUN   = 2'd1;
  localparam logic [1:0] SRC_WAIT  = 2'd2;
  localparam logic [1:0] SRC_AUTO  = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit position that never matches a real digit: "no decimal point".
  localparam logic [2:0] DP_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Segment code {g,f,e,d,c,b,a}, active-high. Non-decimal nibbles blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit carrying the decimal point: money xxxx.x, run xx.xxx km.
  function automatic logic [2:0] dp_digit(input logic [1:0] s);
    logic [2:0] p;
    case (s)
      SRC_MONEY: p = 3'd1;
      SRC_RUN:   p = 3'd3;
      default:   p = DP_NONE;
    endcase
    return p;
  endfunction

  // Lowest digit that may be blanked as a leading zero; digits below it
  // are always lit so fractional parts and "0.x" forms stay readable.
  function automatic logic [2:0] min_shown(input logic [1:0] s);
    logic [2:0] m;
    case (s)
      SRC_MONEY: m = 3'd2;
      SRC_RUN:   m = 3'd4;
      default:   m = 3'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/taxi_display_bin2bcd_seq.sv
// Iterative 18-bit binary to 6-digit BCD converter (shift-add-3).
//   cp, reset : clock, synchronous active-high reset
//   start     : in LOAD, latch bin and begin a conversion
//   bin       : binary input, sampled only in LOAD
//   busy      : high during the 18 SHIFT cycles
//   done      : high for the single DONE cycle; bcd is valid then
//   bcd       : 6 packed BCD nibbles, nibble 0 least significant
//   state     : current FSM state, for observation
// Sequence: LOAD (1) -> SHIFT (18) -> DONE (1) -> LOAD.
module bin2bcd_seq
  import taxi_disp_pkg::*;
(
  input  logic            cp,
  input  logic            reset,
  input  logic            start,
  input  logic [BINW-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [BCDW-1:0] bcd,
  output conv_state_e     state
);

  localparam logic [4:0] LAST_BIT = 5'(BINW - 1);

  conv_state_e     state_q, state_d;
  logic [BINW-1:0] bin_q, bin_d;
  logic [BCDW-1:0] bcd_q, bcd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [BCDW-1:0] adj;

  // State register (datapath registers share the same reset).
  always_ff @(posedge cp) begin
    if (reset) begin
      state_q <= ST_LOAD;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // Datapath: one binary bit moves into the BCD accumulator per SHIFT cycle.
  // Nibbles >= 5 are pre-corrected by +3 so the doubling carries in decimal.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    case (state_q)
      ST_LOAD: begin
        if (start) begin
          bin_d = bin;
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        for (int i = 0; i < NDIG; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 5'd1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy  = (state_q == ST_SHIFT);
    done  = (state_q == ST_DONE);
    bcd   = bcd_q;
    state = state_q;
  end

endmodule

// File: rtl/taxi_display.sv
// Taxi meter display driver.
//   cp, reset : clock, synchronous active-high reset
//   sel       : 0 money, 1 run, 2 waitTime, 3 auto-rotate
//   money     : fare in 0.1 yuan
//   run       : distance in metres
//   waitTime  : waiting time in minutes
//   seg, dp   : segment {g,f,e,d,c,b,a} and decimal point, active-high
//   an        : digit enables, active-low, an[0] rightmost
//   src       : source currently on the display
//   busy      : conversion in progress
// The selected source is converted to BCD continuously (one result every
// 20 cycles), formatted into a 6-entry digit register, and scanned out one
// digit at a time. In auto mode the source advances once every ROT_FRAMES
// complete scan frames.
module taxi_display
  import taxi_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int ROT_FRAMES = 500
) (
  input  logic        cp,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic [13:0] money,
  input  logic [17:0] run,
  input  logic [15:0] waitTime,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic [1:0]  src,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(ROT_FRAMES - 1);

  // Converter interface.
  conv_state_e     conv_state;
  logic            conv_busy;
  logic            conv_done;
  logic [BCDW-1:0] conv_bcd;
  logic [BINW-1:0] act_val;
  logic [1:0]      act_src;

  // Registers.
  logic [NDIG-1:0][7:0] dig_q, dig_d;    // {dp, seg} per digit
  logic [1:0]           src_load_q, src_load_d;
  logic [1:0]           src_q, src_d;
  logic [2:0]           idx_q, idx_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic [1:0]           rot_q, rot_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [5:0]           an_q, an_d;

  logic                 presc_wrap;
  logic                 frame_end;
  logic                 lead;
  logic [3:0]           nib;

  bin2bcd_seq u_conv (
    .cp    (cp),
    .reset (reset),
    .start (1'b1),
    .bin   (act_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .state (conv_state)
  );

  always_ff @(posedge cp) begin
    if (reset) begin
      dig_q      <= '0;
      src_load_q <= SRC_MONEY;
      src_q      <= SRC_MONEY;
      idx_q      <= '0;
      presc_q    <= '0;
      frame_q    <= '0;
      rot_q      <= SRC_MONEY;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      an_q       <= 6'b111111;
    end else begin
      dig_q      <= dig_d;
      src_load_q <= src_load_d;
      src_q      <= src_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      frame_q    <= frame_d;
      rot_q      <= rot_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  // Source selection. The value is only consumed in LOAD, so sel and the
  // meter inputs may change at any time without disturbing a conversion.
  always_comb begin
    act_src = (sel == SRC_AUTO) ? rot_q : sel;
    case (act_src)
      SRC_MONEY: act_val = BINW'(money);
      SRC_RUN:   act_val = run;
      SRC_WAIT:  act_val = BINW'(waitTime);
      default:   act_val = '0;
    endcase
    // Remember which source this conversion belongs to.
    src_load_d = src_load_q;
    if (conv_state == ST_LOAD) src_load_d = act_src;
  end

  // Formatting at DONE: walk from the most significant digit down; a digit
  // is blank while every digit above it (and itself) is zero, unless it is
  // at or below the always-shown boundary for this source.
  always_comb begin
    dig_d = dig_q;
    src_d = src_q;
    lead  = 1'b1;
    nib   = '0;
    if (conv_done) begin
      src_d = src_load_q;
      for (int i = NDIG - 1; i >= 0; i--) begin
        nib  = conv_bcd[4*i +: 4];
        lead = lead && (nib == 4'd0);
        if (lead && (3'(i) >= min_shown(src_load_q))) begin
          dig_d[i] = {1'b0, SEG_BLANK};
        end else begin
          dig_d[i] = {(3'(i) == dp_digit(src_load_q)), seg_code(nib)};
        end
      end
    end
  end

  // Scan and rotate counters.
  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    frame_end  = presc_wrap && (idx_q == 3'd5);
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);

    idx_d = idx_q;
    if (presc_wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    frame_d = frame_q;
    rot_d   = rot_q;
    if (frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        rot_d   = (rot_q == SRC_WAIT) ? SRC_MONEY : rot_q + 2'd1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Digit drive: an, seg and dp are all registered from the next index so
  // the enable and its segment pattern switch on the same edge.
  always_comb begin
    an_d          = ~(6'd1 << idx_d);
    {dp_d, seg_d} = dig_q[idx_d];
  end

  always_comb begin
    seg  = seg_q;
    dp   = dp_q;
    an   = an_q;
    src  = src_q;
    busy = conv_busy;
  end

endmodule
